// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave: 32-bit words, programmable wait states, two-cycle ERROR on illegal access.
// Optional write protection of the upper region is enabled with `define AHB_SLV_PROT_EN.
module ahb_sram_slave #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int PROT_BASE   = 768
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic [3:0]  HMASTER,
    input  logic [31:0] HWDATA,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            ph_vld, ph_write;
    logic [AW-1:0]   ph_idx;
    logic [1:0]      ph_size, ph_lo;
    logic [3:0]      be;
    logic            accept, bad, bad_base, prot_hit, complete;
    logic [3:0][7:0] mem [DEPTH];

    assign accept   = HSEL & HREADY & HTRANS[1];
    assign prot_hit = HWRITE & ~HPROT[1] & ({2'b00, HADDR[31:2]} >= 32'(PROT_BASE));
    assign bad_base = ({2'b00, HADDR[31:2]} >= 32'(DEPTH)) | (HSIZE > 3'b010)
                    | ((HSIZE == 3'b001) & HADDR[0])
                    | ((HSIZE == 3'b010) & (|HADDR[1:0]));
`ifdef AHB_SLV_PROT_EN
    assign bad = bad_base | prot_hit;
`else
    assign bad = bad_base;
`endif

    logic unused;
    assign unused = ^{HBURST, HMASTER, HMASTLOCK, HTRANS[0], HPROT, prot_hit};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = 2'b00;
        unique case (state_q)
            ST_WAIT: begin
                HREADYOUT = 1'b0;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 2'b01;
                state_d   = ST_ERR2;
            end
            default: begin
                // ERR2 finishes the error response but samples a new address like IDLE
                if (state_q == ST_ERR2) HRESP = 2'b01;
                if (HREADY) begin
                    state_d = ST_IDLE;
                    if (accept & bad) begin
                        state_d = ST_ERR1;
                    end else if (accept && (WAIT_STATES > 0)) begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_STATES - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 4'd0;
            ph_vld   <= 1'b0;
            ph_write <= 1'b0;
            ph_idx   <= '0;
            ph_size  <= 2'b00;
            ph_lo    <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (HREADY & HREADYOUT) begin
                ph_vld   <= accept & ~bad;
                ph_write <= HWRITE;
                ph_idx   <= HADDR[AW+1:2];
                ph_size  <= HSIZE[1:0];
                ph_lo    <= HADDR[1:0];
            end
        end
    end

    // A legal data phase finishes in the first IDLE cycle after its address phase
    assign complete = ph_vld & (state_q == ST_IDLE);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        localparam logic [1:0] LN = 2'(i);
        assign be[i] = ph_size[1] | (ph_size[0] ? (ph_lo[1] == LN[1]) : (ph_lo == LN));
    end

    always_ff @(posedge HCLK) begin
        if (HRESETn & complete & ph_write) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ph_idx][i] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA = (complete & ~ph_write) ? mem[ph_idx] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Randomized bench for ahb_sram_slave: two instances (0 and 2 wait states) against a
// transaction-level memory model that predicts every cycle of each data phase.
module tb_ahb_sram_slave;
    localparam int DEPTH = 1024;
    localparam int PB    = 768;
    localparam int MAXB  = 64;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    logic [1:0]  hsel;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] rd0, rd1, c_rd;
    logic        ro0, ro1, c_ro, hready;
    logic [1:0]  rs0, rs1, c_rs;
    int          own;

    always_comb begin
        c_rd = (own == 1) ? rd1 : rd0;
        c_ro = (own == 1) ? ro1 : ro0;
        c_rs = (own == 1) ? rs1 : rs0;
    end
    assign hready = c_ro;

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(0), .PROT_BASE(PB)) u0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[0]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(hprot), .HMASTER(4'h0),
        .HWDATA(hwdata), .HMASTLOCK(1'b0), .HREADY(hready),
        .HRDATA(rd0), .HREADYOUT(ro0), .HRESP(rs0));

    ahb_sram_slave #(.DEPTH(DEPTH), .WAIT_STATES(2), .PROT_BASE(PB)) u1 (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel[1]), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'b000), .HPROT(hprot), .HMASTER(4'h0),
        .HWDATA(hwdata), .HMASTLOCK(1'b0), .HREADY(hready),
        .HRDATA(rd1), .HREADYOUT(ro1), .HRESP(rs1));

    int nchk = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // beat list: kind 0 = unselected, 1 = IDLE, 2 = BUSY, 3 = NONSEQ transfer
    int          n;
    int          bk  [MAXB];
    bit          bw  [MAXB];
    bit          bb  [MAXB];
    logic [31:0] ba  [MAXB];
    logic [2:0]  bs  [MAXB];
    logic [31:0] bd  [MAXB];
    logic [3:0]  bp  [MAXB];
    logic [31:0] obs [MAXB];
    logic [1:0]  obr [MAXB];
    logic [31:0] mm  [2][DEPTH];

    function automatic bit is_bad(input bit w, input logic [31:0] a, input logic [2:0] s,
                                  input logic [3:0] p);
        bit b;
        b = ((a >> 2) >= DEPTH) || (s > 2) || (s == 1 && a[0]) || (s == 2 && a[1:0] != 2'b00);
`ifdef AHB_SLV_PROT_EN
        b = b || (w && !p[1] && ((a >> 2) >= PB));
`else
        if (w && p[1]) b = b;
`endif
        return b;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dt,
                                          input logic [31:0] a, input logic [2:0] s);
        logic [31:0] r;
        bit hit;
        r = old;
        for (int b = 0; b < 4; b++) begin
            hit = (s == 2) || (s == 1 && (b / 2) == int'(a[1])) || (s == 0 && b == int'(a[1:0]));
            if (hit) r[8*b +: 8] = dt[8*b +: 8];
        end
        return r;
    endfunction

    task automatic add(input int k, input bit w, input logic [31:0] a, input logic [2:0] s,
                       input logic [31:0] dt, input logic [3:0] p);
        if (n < MAXB) begin
            bk[n] = k; bw[n] = w; ba[n] = a; bs[n] = s; bd[n] = dt; bp[n] = p;
            bb[n] = (k == 3) && is_bad(w, a, s, p);
            obs[n] = '0; obr[n] = '0;
            n++;
        end
    endtask

    task automatic drive(input int d, input int i);
        hsel = 2'b00; htrans = 2'b00; haddr = '0; hwrite = 1'b0; hsize = 3'b000; hprot = 4'h0;
        if (i < n) begin
            if (bk[i] != 0) hsel[d] = 1'b1;
            htrans = (bk[i] == 3) ? 2'b10 : ((bk[i] == 2) ? 2'b01 : 2'b00);
            haddr = ba[i]; hwrite = bw[i]; hsize = bs[i]; hprot = bp[i];
        end
    endtask

    // Pipelined driver: address phase of beat i overlaps data phase of beat cur
    task automatic run_beats(input int d);
        int i, cur, k, ws;
        bit rdy, fin, done;
        logic [31:0] e_rd;
        i = 0; cur = -1; k = 0; done = 0; own = d;
        ws = (d == 1) ? 2 : 0;
        drive(d, 0);
        hwdata = '0;
        for (int cyc = 0; cyc < 4 * MAXB + 20 && !done; cyc++) begin
            @(negedge HCLK);
            fin = 1'b1;
            e_rd = '0;
            if (cur >= 0) begin
                fin = bb[cur] ? (k == 1) : (k == ws);
                if (fin && !bb[cur] && !bw[cur]) e_rd = mm[d][ba[cur] >> 2];
                chk($sformatf("d%0d b%0d k%0d ready", d, cur, k), 32'(c_ro), 32'(fin));
                chk($sformatf("d%0d b%0d k%0d resp", d, cur, k), 32'(c_rs), bb[cur] ? 32'd1 : 32'd0);
                chk($sformatf("d%0d b%0d k%0d rdata", d, cur, k), c_rd, e_rd);
                if (fin) begin
                    obs[cur] = c_rd;
                    obr[cur] = c_rs;
                end
            end else begin
                chk($sformatf("d%0d idle ready", d), 32'(c_ro), 32'd1);
                chk($sformatf("d%0d idle resp", d), 32'(c_rs), 32'd0);
                chk($sformatf("d%0d idle rdata", d), c_rd, 32'd0);
            end
            rdy = c_ro;
            @(posedge HCLK);
            if (rdy) begin
                if (cur >= 0 && !bb[cur] && bw[cur])
                    mm[d][ba[cur] >> 2] = merge(mm[d][ba[cur] >> 2], bd[cur], ba[cur], bs[cur]);
                cur = (i < n && bk[i] == 3) ? i : -1;
                k = 0;
                if (i < n) i++;
                done = (i >= n) && (cur < 0);
            end else begin
                k++;
                if (k > ws + 2) begin
                    chk($sformatf("d%0d b%0d stall", d, cur), 32'(k), 32'(ws + 1));
                    done = 1'b1;
                end
            end
            #1;
            drive(d, i);
            hwdata = (cur >= 0) ? bd[cur] : 32'h0;
        end
        chk($sformatf("d%0d run_done", d), 32'(done), 32'd1);
        hsel = 2'b00;
        htrans = 2'b00;
    endtask

    task automatic gen_random(input int cnt);
        int r;
        bit w;
        logic [2:0] s;
        logic [31:0] a;
        for (int j = 0; j < cnt; j++) begin
            r = $urandom_range(0, 11);
            w = 1'($urandom_range(0, 1));
            s = 3'($urandom_range(0, 2));
            a = 32'($urandom_range(0, 31)) * 4;
            if (s == 0) a = a + 32'($urandom_range(0, 3));
            else if (s == 1) a = a + 32'(2 * $urandom_range(0, 1));
            case (r)
                0: add(0, w, a, s, $urandom, 4'h3);
                1: add(1, w, a, s, $urandom, 4'h3);
                2: add(2, w, a, s, $urandom, 4'h3);
                3: add(3, w, 32'(DEPTH * 4) + (a & 32'hFC), 3'b010, $urandom, 4'h3);
                4: add(3, w, a & 32'hFC, 3'b011, $urandom, 4'h3);
                5: add(3, w, (a & 32'hFC) | 32'h1, 3'b001, $urandom, 4'h3);
                default: add(3, w, a, s, $urandom, 4'($urandom_range(0, 15)));
            endcase
        end
    endtask

    logic [31:0] w0;

    initial begin
        own = 0; hsel = 2'b00; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'b000; hprot = 4'h0; hwdata = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst u0 ready", 32'(ro0), 32'd1);
        chk("rst u0 resp", 32'(rs0), 32'd0);
        chk("rst u0 rdata", rd0, 32'd0);
        chk("rst u1 ready", 32'(ro1), 32'd1);
        chk("rst u1 resp", 32'(rs1), 32'd0);
        chk("rst u1 rdata", rd1, 32'd0);
        @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int d = 0; d < 2; d++) begin
            n = 0;
            for (int w = 0; w < 32; w++) add(3, 1'b1, 32'(w * 4), 3'b010, $urandom, 4'h3);
            add(3, 1'b1, 32'(PB * 4), 3'b010, 32'hA5A5A5A5, 4'h3);
            run_beats(d);

            n = 0;
            add(3, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, 4'h3);
            add(3, 1'b0, 32'h10, 3'b010, 32'h0, 4'h3);
            add(3, 1'b1, 32'h20, 3'b010, 32'h12345678, 4'h3);
            add(3, 1'b0, 32'h20, 3'b010, 32'h0, 4'h3);
            run_beats(d);
            chk($sformatf("d%0d raw 0x10", d), obs[1], 32'hDEADBEEF);
            chk($sformatf("d%0d read 0x20", d), obs[3], 32'h12345678);

            n = 0;
            add(3, 1'b1, 32'h04, 3'b010, 32'h11223344, 4'h3);
            add(3, 1'b1, 32'h07, 3'b000, 32'hAB000000, 4'h3);
            add(3, 1'b0, 32'h04, 3'b010, 32'h0, 4'h3);
            add(3, 1'b1, 32'h04, 3'b001, 32'h0000BEEF, 4'h3);
            add(3, 1'b0, 32'h04, 3'b010, 32'h0, 4'h3);
            run_beats(d);
            chk($sformatf("d%0d byte lane", d), obs[2], 32'hAB223344);
            chk($sformatf("d%0d half lane", d), obs[4], 32'hAB22BEEF);

            n = 0;
            w0 = mm[d][0];
            add(3, 1'b0, 32'(DEPTH * 4), 3'b010, 32'h0, 4'h3);
            add(3, 1'b1, 32'h01, 3'b001, 32'hFFFFFFFF, 4'h3);
            add(3, 1'b0, 32'h00, 3'b010, 32'h0, 4'h3);
            run_beats(d);
            chk($sformatf("d%0d oor resp", d), 32'(obr[0]), 32'd1);
            chk($sformatf("d%0d misalign resp", d), 32'(obr[1]), 32'd1);
            chk($sformatf("d%0d misalign nowrite", d), obs[2], w0);

            n = 0;
            add(3, 1'b1, 32'(PB * 4), 3'b010, 32'h55, 4'b0001);
            add(3, 1'b0, 32'(PB * 4), 3'b010, 32'h0, 4'h3);
            run_beats(d);
`ifdef AHB_SLV_PROT_EN
            chk($sformatf("d%0d prot resp", d), 32'(obr[0]), 32'd1);
            chk($sformatf("d%0d prot data", d), obs[1], 32'hA5A5A5A5);
`else
            chk($sformatf("d%0d prot resp", d), 32'(obr[0]), 32'd0);
            chk($sformatf("d%0d prot data", d), obs[1], 32'h55);
`endif
        end

        // reset in the middle of a waited write on the 2-wait-state slave
        own = 1;
        hsel = 2'b10; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b1; hsize = 3'b010; hprot = 4'h3;
        @(posedge HCLK);
        #1;
        hsel = 2'b00; htrans = 2'b00; hwdata = 32'hFFFFFFFF; HRESETn = 1'b0;
        @(negedge HCLK);
        chk("mid-write ready", 32'(ro1), 32'd0);
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("in-rst ready", 32'(ro1), 32'd1);
        chk("in-rst resp", 32'(rs1), 32'd0);
        chk("in-rst rdata", rd1, 32'd0);
        @(posedge HCLK);
        #1 HRESETn = 1'b0;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("post-rst ready", 32'(ro1), 32'd1);
        chk("post-rst resp", 32'(rs1), 32'd0);
        @(posedge HCLK);
        #1;
        n = 0;
        add(3, 1'b0, 32'h20, 3'b010, 32'h0, 4'h3);
        run_beats(1);
        chk("rst no commit", obs[0], 32'h12345678);

        for (int rnd = 0; rnd < 3; rnd++) begin
            for (int d = 0; d < 2; d++) begin
                n = 0;
                gen_random(48);
                run_beats(d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", nchk);
        $fatal(1);
    end

endmodule
